// File: rtl/keypad_scanner_pkg.sv
// Shared constants and key numbering for the 4x4 keypad scanner.
// Key index matches the LED matrix pixel numbering: row*4 + col.
package keypad_scanner_pkg;
  localparam int KP_ROWS  = 4;
  localparam int KP_COLS  = 4;
  localparam int KP_KEYS  = 16;
  localparam int KP_IDX_W = 4;

  typedef logic [KP_IDX_W-1:0] key_idx_t;

  typedef struct packed {
    key_idx_t key;
    logic     down;
  } kp_evt_t;

  function automatic key_idx_t key_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/keypad_scanner_key_debounce.sv
// One key's debouncer: a new level is accepted after DEBOUNCE consecutive
// differing samples; en is the row's sample strobe.
module key_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic state,
  output logic chg
);
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chg     = 1'b0;
    if (en) begin
      if (raw == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = raw;
        cnt_d   = '0;
        chg     = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;
endmodule

// File: rtl/keypad_scanner.sv
// Row-scanned 4x4 keypad with per-key debounce and a valid/ready event port.
// Changes are queued in a pending mask and reported lowest index first.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SETTLE   = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                clk,
  input  logic                rst,
  output logic [KP_ROWS-1:0]  rows_n,
  input  logic [KP_COLS-1:0]  cols_n,
  output logic [KP_KEYS-1:0]  keys,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KP_IDX_W-1:0] evt_key,
  output logic                evt_down,
  output logic                overflow
);
  localparam int PH_W = $clog2(SETTLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SETTLE - 1);

  logic [1:0]         row_q, row_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [KP_COLS-1:0] sync1_q, sync2_q;
  logic [KP_KEYS-1:0] keys_w, chg_w;
  logic [KP_KEYS-1:0] pend_q, pend_d, clr_w;
  logic               evt_valid_q, evt_valid_d;
  kp_evt_t            evt_q, evt_d;
  logic               ovf_q, ovf_d;
  logic               sample, load;
  key_idx_t           pick;

  assign sample = (phase_q == PH_LAST);

  always_comb begin
    phase_d = sample ? '0 : phase_q + 1'b1;
    row_d   = sample ? row_q + 2'd1 : row_q;
  end

  // Rows float high for the whole time rst is asserted.
  assign rows_n = rst ? '1 : ~(KP_ROWS'(1) << row_q);

  for (genvar r = 0; r < KP_ROWS; r++) begin : g_row
    for (genvar c = 0; c < KP_COLS; c++) begin : g_col
      key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key (
        .clk   (clk),
        .rst   (rst),
        .en    (sample && (row_q == 2'(r))),
        .raw   (~sync2_q[c]),
        .state (keys_w[key_idx(2'(r), 2'(c))]),
        .chg   (chg_w[key_idx(2'(r), 2'(c))])
      );
    end
  end

  always_comb begin
    pick = '0;
    for (int i = KP_KEYS - 1; i >= 0; i--) begin
      if (pend_q[i]) pick = key_idx_t'(i);
    end
  end

  // A fresh change on the key being cleared re-sets its bit without overflow.
  always_comb begin
    load        = (!evt_valid_q || evt_ready) && (pend_q != '0);
    clr_w       = load ? (KP_KEYS'(1) << pick) : '0;
    pend_d      = (pend_q & ~clr_w) | chg_w;
    ovf_d       = ovf_q | ((chg_w & pend_q & ~clr_w) != '0);
    evt_valid_d = evt_valid_q;
    evt_d       = evt_q;
    if (load) begin
      evt_valid_d = 1'b1;
      evt_d.key   = pick;
      evt_d.down  = keys_w[pick];
    end else if (evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q       <= '0;
      phase_q     <= '0;
      sync1_q     <= '1;
      sync2_q     <= '1;
      pend_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      row_q       <= row_d;
      phase_q     <= phase_d;
      sync1_q     <= cols_n;
      sync2_q     <= sync1_q;
      pend_q      <= pend_d;
      evt_valid_q <= evt_valid_d;
      evt_q       <= evt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign keys      = keys_w;
  assign evt_valid = evt_valid_q;
  assign evt_key   = evt_q.key;
  assign evt_down  = evt_q.down;
  assign overflow  = ovf_q;
endmodule
